// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : alu_pipe
// Description : Handshaked, parametrised ALU that sits between register read
//               and writeback/branch. Results are registered and held until
//               the consumer takes them. Adds a signed-overflow flag.
//               The iterative shift-add multiply (op 1010) is built only when
//               the macro ALU_PIPE_MUL_EN is defined; otherwise op 1010
//               decodes as ADD.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             Overflow
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_SRL  = 4'b0010;
  localparam logic [3:0] OP_SLT  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
`ifdef ALU_PIPE_MUL_EN
  localparam logic [3:0]     OP_MUL   = 4'b1010;
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             ovf_q;

`ifdef ALU_PIPE_MUL_EN
  // Multiplier datapath: multiplicand shifts left, multiplier shifts right,
  // one multiplier bit consumed per cycle.
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_d;
`endif

  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] diff_d;
  logic [SHW-1:0]   shamt_d;
  logic             add_ovf_d;
  logic             sub_ovf_d;
  logic [WIDTH-1:0] alu_res_d;
  logic             alu_ovf_d;
  logic             accept_d;

  assign sum_d   = SrcA + SrcB;
  assign diff_d  = SrcA - SrcB;
  assign shamt_d = SrcB[SHW-1:0];

  // Same-sign operands producing a result of the other sign.
  assign add_ovf_d = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) &&
                     (sum_d[WIDTH-1] != SrcA[WIDTH-1]);
  // Opposite-sign operands where the result sign departs from SrcA.
  assign sub_ovf_d = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) &&
                     (diff_d[WIDTH-1] != SrcA[WIDTH-1]);

  // Handshake: a held result blocks new work until the consumer drains it.
  assign InReady  = (state_q == IDLE) || ((state_q == DONE) && OutReady);
  assign accept_d = InValid && InReady;

  assign OutValid  = out_valid_q;
  assign ALUResult = result_q;
  assign Zero      = (result_q == '0);
  assign Overflow  = ovf_q;

`ifdef ALU_PIPE_MUL_EN
  // Partial-product accumulate for the current multiplier bit.
  assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif

  // Single-cycle operation decode; unlisted codes fall back to ADD.
  always_comb begin
    alu_res_d = sum_d;
    alu_ovf_d = add_ovf_d;
    case (ALUControl)
      OP_ADD: begin
        alu_res_d = sum_d;
        alu_ovf_d = add_ovf_d;
      end
      OP_OR: begin
        alu_res_d = SrcA | SrcB;
        alu_ovf_d = 1'b0;
      end
      OP_SRL: begin
        alu_res_d = SrcA >> shamt_d;
        alu_ovf_d = 1'b0;
      end
      OP_SLT: begin
        alu_res_d = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
        alu_ovf_d = 1'b0;
      end
      OP_SUB: begin
        alu_res_d = diff_d;
        alu_ovf_d = sub_ovf_d;
      end
      OP_AND: begin
        alu_res_d = SrcA & SrcB;
        alu_ovf_d = 1'b0;
      end
      OP_XOR: begin
        alu_res_d = SrcA ^ SrcB;
        alu_ovf_d = 1'b0;
      end
      OP_SLL: begin
        alu_res_d = SrcA << shamt_d;
        alu_ovf_d = 1'b0;
      end
      OP_SRA: begin
        alu_res_d = $unsigned($signed(SrcA) >>> shamt_d);
        alu_ovf_d = 1'b0;
      end
      OP_SLTU: begin
        alu_res_d = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
        alu_ovf_d = 1'b0;
      end
      default: begin
        alu_res_d = sum_d;
        alu_ovf_d = add_ovf_d;
      end
    endcase
  end

  // Control FSM with registered result, flags and OutValid.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept_d) begin
`ifdef ALU_PIPE_MUL_EN
            if (ALUControl == OP_MUL) begin
              state_q     <= BUSY;
              out_valid_q <= 1'b0;
              cnt_q       <= '0;
              acc_q       <= '0;
              mcand_q     <= SrcA;
              mplier_q    <= SrcB;
            end else begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              result_q    <= alu_res_d;
              ovf_q       <= alu_ovf_d;
            end
`else
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            result_q    <= alu_res_d;
            ovf_q       <= alu_ovf_d;
`endif
          end else if ((state_q == DONE) && OutReady) begin
            // Result consumed with nothing new: ALUResult keeps its value.
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
`ifdef ALU_PIPE_MUL_EN
        BUSY: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            result_q    <= acc_d;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
          end
        end
`endif
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
